// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer controller: state encodings,
// the default prescaler divide ratio and a small state-classification helper.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADING = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int unsigned DEFAULT_CLK_DIV = 32'd100;

  // States in which a stop command must also clear the digit counter chain.
  function automatic logic stop_clears(input state_t st);
    logic res;
    case (st)
      ST_RUN, ST_PAUSE, ST_DONE: res = 1'b1;
      default:                   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler for the timer: counts 0..CLK_DIV-1 while run is high and flags
// the last count with tick. restart forces the count back to zero so the
// first tick after (re)entering RUN comes a full CLK_DIV cycles later.
// Outside RUN the count is frozen.
module tick_gen
  import timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clock,
  input  logic clearn,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST_COUNT = 16'(CLK_DIV - 32'd1);

  logic [15:0] count_r;

  // Prescaler count: restart to zero, advance and wrap in RUN, hold otherwise.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      count_r <= 16'd0;
    end else if (restart) begin
      count_r <= 16'd0;
    end else if (run) begin
      count_r <= (count_r == LAST_COUNT) ? 16'd0 : count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign tick = run && (count_r == LAST_COUNT);

endmodule

// File: rtl/timer_controller.sv
// Countdown timer controller driving an external chain of BCD digit counters.
// Commands (stop > pause > start > load) steer a five-state FSM; the prescaler
// sub-module paces decrements of the chain while running.
// Optional build macro TIMER_DOOR_INTERLOCK_EN: an open door forces RUN into
// PAUSE and blocks start; without it door_open has no effect.
module timer_controller
  import timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       load,
  input  logic       zero_all,
  input  logic       door_open,
  output logic       cnt_en,
  output logic       cnt_loadn,
  output logic       cnt_clearn,
  output logic       running,
  output logic       done,
  output logic [2:0] state
);

  state_t state_r;
  state_t state_next_s;
  logic   clear_req_s;
  logic   door_block_s;
  logic   start_ok_s;
  logic   restart_s;
  logic   tick_s;
  logic   cnt_loadn_r;
  logic   cnt_clearn_r;

`ifdef TIMER_DOOR_INTERLOCK_EN
  assign door_block_s = door_open;
`else
  logic door_unused_s;
  assign door_unused_s = door_open;
  assign door_block_s  = 1'b0;
`endif

  assign start_ok_s = start && !door_block_s;

  // State register.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; the highest-priority asserted command is the one acted on.
  always_comb begin
    state_next_s = ST_IDLE;
    clear_req_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (stop || pause) begin
          state_next_s = ST_IDLE;
        end else if (start) begin
          state_next_s = (start_ok_s && !zero_all) ? ST_RUN : ST_IDLE;
        end else if (load) begin
          state_next_s = ST_LOADING;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOADING: begin
        state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (stop) begin
          state_next_s = ST_IDLE;
          clear_req_s  = 1'b1;
        end else if (pause || door_block_s) begin
          state_next_s = ST_PAUSE;
        end else if (zero_all) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_next_s = ST_IDLE;
          clear_req_s  = 1'b1;
        end else if (pause) begin
          state_next_s = ST_PAUSE;
        end else if (start) begin
          state_next_s = start_ok_s ? ST_RUN : ST_PAUSE;
        end else if (load) begin
          state_next_s = ST_LOADING;
        end else begin
          state_next_s = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_next_s = ST_IDLE;
          clear_req_s  = stop_clears(state_r);
        end else if (pause) begin
          state_next_s = ST_DONE;
        end else if (start) begin
          state_next_s = start_ok_s ? ST_IDLE : ST_DONE;
        end else if (load) begin
          state_next_s = ST_LOADING;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        clear_req_s  = 1'b0;
      end
    endcase
  end

  // Any entry into RUN (from IDLE or PAUSE) restarts the prescaler.
  assign restart_s = (state_next_s == ST_RUN) && (state_r != ST_RUN);

  // Registered chain controls: clear pulse after a stop, load strobe during LOADING.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      cnt_clearn_r <= 1'b0;
      cnt_loadn_r  <= 1'b1;
    end else begin
      cnt_clearn_r <= !clear_req_s;
      cnt_loadn_r  <= (state_next_s != ST_LOADING);
    end
  end

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clock   (clock),
    .clearn  (clearn),
    .run     (state_r == ST_RUN),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // State-decoded outputs; the enable is gated by zero_all so the chain never wraps.
  always_comb begin
    running = (state_r == ST_RUN);
    done    = (state_r == ST_DONE);
    cnt_en  = tick_s && !zero_all;
  end

  assign cnt_loadn  = cnt_loadn_r;
  assign cnt_clearn = cnt_clearn_r;
  assign state      = state_r;

endmodule

// File: tb/tb_timer_controller.sv
// Self-checking bench for timer_controller (CLK_DIV=4). A behavioural model
// of the controller plus a model of the digit counter chain (an integer that
// is preset, decremented and cleared) supplies zero_all and every expected
// output. Directed scenarios come first, then randomized commands.
module tb_timer_controller;

  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       clearn, start, pause, stop, load, zero_all, door_open;
  logic       cnt_en, cnt_loadn, cnt_clearn, running, done;
  logic [2:0] state;

  timer_controller #(.CLK_DIV(DIV)) dut (
    .clock      (clock),
    .clearn     (clearn),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .load       (load),
    .zero_all   (zero_all),
    .door_open  (door_open),
    .cnt_en     (cnt_en),
    .cnt_loadn  (cnt_loadn),
    .cnt_clearn (cnt_clearn),
    .running    (running),
    .done       (done),
    .state      (state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0..4 = IDLE, LOADING, RUN, PAUSE, DONE
  int m_mode       = 0;
  int m_run_cycles = 0;   // cycles spent in RUN since the last entry
  int m_clearn     = 0;
  int m_loadn      = 1;
  int chain        = 0;   // value held by the digit counter chain
  int preset       = 0;
  int en_seen      = 0;
  bit interlock    = 1'b0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all outputs against the model for the current cycle.
  task automatic check_all(input logic exp_en);
    expect_eq("state",      32'(state),      32'(m_mode));
    expect_eq("running",    32'(running),    32'(m_mode == 2));
    expect_eq("done",       32'(done),       32'(m_mode == 4));
    expect_eq("cnt_en",     32'(cnt_en),     32'(exp_en));
    expect_eq("cnt_loadn",  32'(cnt_loadn),  32'(m_loadn));
    expect_eq("cnt_clearn", 32'(cnt_clearn), 32'(m_clearn));
  endtask

  // One clock cycle: drive commands at the falling edge, check, advance the model.
  task automatic step(input bit s_start, input bit s_pause, input bit s_stop,
                      input bit s_load, input bit s_door);
    int  cmd;   // 3 stop, 2 pause, 1 start, 0 load, -1 none
    int  nxt;
    bit  blocked, zero, exp_en, clr;
    start = s_start; pause = s_pause; stop = s_stop; load = s_load;
    door_open = s_door;
    zero = (chain == 0);
    zero_all = zero;
    #1;
    exp_en = (m_mode == 2) && ((m_run_cycles % DIV) == DIV - 1) && !zero;
    check_all(exp_en);
    if (cnt_en === 1'b1) en_seen++;

    if (s_stop) cmd = 3;
    else if (s_pause) cmd = 2;
    else if (s_start) cmd = 1;
    else if (s_load) cmd = 0;
    else cmd = -1;
    blocked = interlock && s_door;
    clr = (cmd == 3) && (m_mode >= 2 && m_mode <= 4);
    case (m_mode)
      0: nxt = (cmd == 1 && !blocked && !zero) ? 2 : (cmd == 0) ? 1 : 0;
      1: nxt = 0;
      2: nxt = (cmd == 3) ? 0 : (cmd == 2 || blocked) ? 3 : zero ? 4 : 2;
      3: nxt = (cmd == 3) ? 0 : (cmd == 1 && !blocked) ? 2 : (cmd == 0) ? 1 : 3;
      4: nxt = (cmd == 3) ? 0 : (cmd == 1 && !blocked) ? 0 : (cmd == 0) ? 1 : 4;
      default: nxt = 0;
    endcase

    // The chain reacts at the coming rising edge to the outputs of this cycle.
    if (m_clearn == 0) chain = 0;
    else if (m_loadn == 0) chain = preset;
    else if (exp_en) chain = chain - 1;

    m_run_cycles = (nxt == 2 && m_mode == 2) ? m_run_cycles + 1 : 0;
    m_clearn = clr ? 0 : 1;
    m_loadn  = (nxt == 1) ? 0 : 1;
    m_mode   = nxt;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset at a falling edge (asynchronously) and hold it for n cycles.
  task automatic do_reset(input int n);
    clearn = 1'b0;
    start = 1'b0; pause = 1'b0; stop = 1'b0; load = 1'b0; door_open = 1'b0;
    m_mode = 0; m_run_cycles = 0; m_clearn = 0; m_loadn = 1; chain = 0;
    zero_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      check_all(1'b0);
      @(posedge clock);
      @(negedge clock);
    end
    clearn = 1'b1;
  endtask

  initial begin
`ifdef TIMER_DOOR_INTERLOCK_EN
    interlock = 1'b1;
`endif
    clearn = 1'b0;
    start = 1'b0; pause = 1'b0; stop = 1'b0; load = 1'b0;
    door_open = 1'b0; zero_all = 1'b1;
    @(negedge clock);
    do_reset(3);
    idle(2);

    // start with an empty chain is ignored
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    expect_eq("start_zero_state", 32'(state), 32'd0);

    // preset 003, run to completion
    preset = 3;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    en_seen = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(20);
    expect_eq("run3_pulses", 32'(en_seen), 32'd3);
    expect_eq("run3_done",   32'(done),    32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // acknowledge

    // pause at cycle 6 of RUN, hold 10 cycles, resume
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    en_seen = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(20);
    expect_eq("pause_pulses", 32'(en_seen), 32'd3);

    // load in DONE, then load ignored in RUN, then stop+start in RUN
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // reset in the middle of RUN
    preset = 5;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(DIV - 2);
    do_reset(2);
    idle(2);

    // door handling: interlock build pauses and rejects start, default ignores it
    preset = 9;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);

    // randomized command stream
    for (int i = 0; i < 4000; i++) begin
      bit r_start, r_pause, r_stop, r_load, r_door;
      if ($urandom_range(0, 599) == 0) begin
        do_reset($urandom_range(1, 3));
      end
      if ($urandom_range(0, 19) == 0) preset = $urandom_range(0, 12);
      r_start = ($urandom_range(0, 5) == 0);
      r_pause = ($urandom_range(0, 24) == 0);
      r_stop  = ($urandom_range(0, 39) == 0);
      r_load  = ($urandom_range(0, 9) == 0);
      r_door  = ($urandom_range(0, 5) == 0);
      step(r_start, r_pause, r_stop, r_load, r_door);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_controller.md
TIMER_CONTROLLER -- requirements
Module: timer_controller

Interface
REQ-001 Parameter CLK_DIV, default 100, clock cycles per count decrement (legal range 2..65535).
REQ-002 clock  input  1  single system clock; all state updates on posedge.
REQ-003 clearn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse, active high; start, resume, or acknowledge done.
REQ-005 pause  input  1  one-cycle pulse, active high; suspend counting.
REQ-006 stop  input  1  one-cycle pulse, active high; abort and clear the counter chain.
REQ-007 load  input  1  one-cycle pulse, active high; request a preset load into the counter chain.
REQ-008 zero_all  input  1  AND of every digit counter's zero output.
REQ-009 door_open  input  1  door sensor, active high; used only when the interlock is compiled in.
REQ-010 cnt_en  output  1  enable to the least-significant digit counter.
REQ-011 cnt_loadn  output  1  synchronous load to all digit counters, active low.
REQ-012 cnt_clearn  output  1  clear to all digit counters, active low.
REQ-013 running  output  1  high in RUN.
REQ-014 done  output  1  high in DONE.
REQ-015 state  output  3  current state encoding.

Function
REQ-016 State encodings SHALL be: IDLE=0, LOADING=1, RUN=2, PAUSE=3, DONE=4; the remaining codes SHALL return to IDLE on the next clock.
REQ-017 When several commands arrive in the same cycle, priority SHALL be stop > pause > start > load.
REQ-018 stop in RUN, PAUSE or DONE SHALL drive cnt_clearn low for exactly one cycle, then the FSM SHALL enter IDLE.
REQ-019 load in IDLE, PAUSE or DONE SHALL enter LOADING; load in RUN SHALL be ignored.
REQ-020 LOADING SHALL last exactly one cycle with cnt_loadn=0 and cnt_en=0, then return to IDLE.
REQ-021 start in IDLE with zero_all=0 SHALL enter RUN; start with zero_all=1 SHALL be ignored.
REQ-022 In RUN, the prescaler SHALL count 0..CLK_DIV-1 and wrap, and tick SHALL be high when the count equals CLK_DIV-1.
REQ-023 cnt_en SHALL equal tick AND NOT zero_all, so the chain never wraps from 0 to 9.
REQ-024 The prescaler SHALL reset to 0 on every entry to RUN, so the first decrement occurs CLK_DIV cycles after entry.
REQ-025 The prescaler SHALL hold its value in every state other than RUN.
REQ-026 In RUN, zero_all=1 SHALL move the FSM to DONE on the next clock.
REQ-027 In RUN, pause SHALL move the FSM to PAUSE.
REQ-028 In PAUSE, start SHALL return the FSM to RUN and restart the prescaler.
REQ-029 In DONE, done SHALL stay high until start or stop (either returns to IDLE) or load (enters LOADING).
REQ-030 cnt_loadn and cnt_clearn SHALL be registered outputs, with no combinational path from any input.
REQ-031 cnt_en and cnt_loadn SHALL never be active in the same cycle.

Reset
REQ-032 While clearn=0, the block SHALL hold: state=IDLE, prescaler=0, cnt_en=0, cnt_loadn=1, done=0, running=0.
REQ-033 While clearn=0, cnt_clearn SHALL be 0, forwarding reset to the chain; it SHALL return to 1 on the first posedge after release.
REQ-034 Reset asserted mid-RUN SHALL abort immediately, with no extra decrement issued.

Configuration
REQ-035 Macro TIMER_DOOR_INTERLOCK_EN, when defined, SHALL apply the following interlock rules:
- door_open=1 in RUN forces PAUSE on the next clock.
- start is ignored while door_open=1.
REQ-036 When TIMER_DOOR_INTERLOCK_EN is undefined, door_open SHALL be ignored entirely.

Structure
REQ-037 Package timer_pkg SHALL hold the state encodings and the default CLK_DIV constant.
REQ-038 The prescaler SHALL be the sub-module tick_gen, with inputs clock, clearn, run, restart and output tick.

Verification (CLK_DIV=4 for all scenarios)
REQ-039 Preset 003 loaded, then start: cnt_en pulses at cycles 4, 8 and 12 after RUN entry; DONE on the cycle after zero_all rises; no further cnt_en.
REQ-040 Pause at cycle 6 of RUN, hold 10 cycles, then start: next cnt_en comes 4 cycles after resume; total cnt_en pulses unchanged.
REQ-041 Stop and start in the same cycle during RUN: one-cycle cnt_clearn=0, then IDLE; start is ignored.
REQ-042 start with zero_all=1 in IDLE: state stays 0 and cnt_en stays 0.
REQ-043 load in RUN is ignored; load in DONE gives one cycle of cnt_loadn=0, then IDLE with done=0.
REQ-044 With TIMER_DOOR_INTERLOCK_EN defined: door_open raised mid-RUN gives PAUSE next cycle; start while the door is open is rejected; after the door closes, start resumes RUN.
